div_unit: RTL and testbench



---
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider feeding the HI (remainder) and LO (quotient) muxes.
// Define DIV_UNSIGNED_EN to add the sign_mode input for DIVU support.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
`ifdef DIV_UNSIGNED_EN
   input  logic             sign_mode,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      FIX,
      ZERO
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             q_neg_q, q_neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic             signed_op;
   logic             sa, sb;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

`ifdef DIV_UNSIGNED_EN
   assign signed_op = sign_mode;
`else
   assign signed_op = 1'b1;
`endif

   assign sa = signed_op & a[WIDTH-1];
   assign sb = signed_op & b[WIDTH-1];

   // Working remainder is one bit wider so the trial subtract's sign is visible.
   assign shifted = {rem_q, quot_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         quot_q   <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         q_neg_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         quot_q   <= quot_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         q_neg_q  <= q_neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      quot_d   = quot_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      q_neg_d  = q_neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD;
               sign_a_d = sa;
               q_neg_d  = sa ^ sb;
               quot_d   = sa ? -a : a;
               dvs_d    = sb ? -b : b;
               rem_d    = '0;
               cnt_d    = '0;
            end
         end
         LOAD: begin
            state_d = (dvs_q == '0) ? ZERO : RUN;
         end
         RUN: begin
            if (!diff[WIDTH]) begin
               rem_d  = diff[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = shifted[WIDTH-1:0];
               quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            lo_d    = q_neg_q ? -quot_q : quot_q;
            hi_d    = sign_a_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         ZERO: begin
            done_d  = 1'b1;
            dz_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed results, latency, divide-by-zero, reset.
// Unsigned-mode vectors are exercised when DIV_UNSIGNED_EN is defined.
module tb_div_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;
`ifdef DIV_UNSIGNED_EN
   logic        sign_mode;
`endif

   int errs;
   int nchk;

   div_unit #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
`ifdef DIV_UNSIGNED_EN
      .sign_mode(sign_mode),
`endif
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulses start, scrambles the operands afterwards, waits for done.
   task automatic run(input string tag, input logic [31:0] av,
                      input logic [31:0] bv, input bit dbl,
                      input int exp_lat, input logic exp_dz,
                      input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int lat;
      @(negedge clock);
      a = av;
      b = bv;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      a = 32'hDEAD_BEEF;
      b = 32'h0000_0000;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 60) begin
         start = dbl && (lat == 5);
         @(negedge clock);
         lat++;
      end
      start = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
      chk({tag, "_lo"}, lo, exp_lo);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      @(negedge clock);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      errs = 0;
      nchk = 0;
      reset = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
`ifdef DIV_UNSIGNED_EN
      sign_mode = 1'b1;
`endif
      #12;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run("n7d2", 32'd7, 32'd2, 1'b0, 34, 1'b0, 32'd3, 32'd1);
      run("nm7d2", 32'hFFFF_FFF9, 32'd2, 1'b0, 34, 1'b0,
          32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run("n7dm2", 32'd7, 32'hFFFF_FFFE, 1'b0, 34, 1'b0,
          32'hFFFF_FFFD, 32'd1);
      run("nm7dm2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 34, 1'b0,
          32'd3, 32'hFFFF_FFFF);
      run("n100d7", 32'd100, 32'd7, 1'b0, 34, 1'b0, 32'd14, 32'd2);
      run("n7d2b", 32'd7, 32'd2, 1'b0, 34, 1'b0, 32'd3, 32'd1);
      run("dz", 32'd100, 32'd0, 1'b0, 2, 1'b1, 32'd3, 32'd1);
      run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 1'b0,
          32'h8000_0000, 32'd0);
      run("zero_num", 32'd0, 32'd5, 1'b0, 34, 1'b0, 32'd0, 32'd0);
      run("n7d2c", 32'd7, 32'd2, 1'b0, 34, 1'b0, 32'd3, 32'd1);

      // Abort an operation partway through RUN.
      @(negedge clock);
      a = 32'd9;
      b = 32'd3;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (11) @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run("n9d3", 32'd9, 32'd3, 1'b1, 34, 1'b0, 32'd3, 32'd0);

`ifdef DIV_UNSIGNED_EN
      sign_mode = 1'b0;
      run("u_ff_d2", 32'hFFFF_FFFF, 32'd2, 1'b0, 34, 1'b0,
          32'h7FFF_FFFF, 32'd1);
      sign_mode = 1'b1;
      run("s_ff_d2", 32'hFFFF_FFFF, 32'd2, 1'b0, 34, 1'b0,
          32'd0, 32'hFFFF_FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
